// File: rtl/pipe_mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer.
package pipe_mdu_ctrl_pkg;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_DIVU  = 2'b01,
        MDU_MTHI  = 2'b10,
        MDU_MTLO  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_RUN  = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_e;

    // MULTU/DIVU go through the iterative loop; MTHI/MTLO are single-cycle writes.
    function automatic logic is_long_op(input mdu_op_e op);
        return (op == MDU_MULTU) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/pipe_mdu_ctrl_if.sv
// EXE-stage <-> MDU handshake and HI/LO read-back bundle.
interface pipe_mdu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             estart;
    logic [1:0]       eop;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic             ecancel;
    logic             mstall;
    logic             mbusy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // EXE stage side
    modport master (
        output estart, eop, ea, eb, ecancel,
        input  mstall, mbusy, hi, lo
    );

    // MDU side
    modport slave (
        input  estart, eop, ea, eb, ecancel,
        output mstall, mbusy, hi, lo
    );
endinterface

// File: rtl/pipe_mdu_ctrl_step.sv
// One iteration of shift-add multiply or restoring divide.
// Accumulator layout is {upper[WIDTH:0], lower[WIDTH-1:0]}:
//   MULTU: upper = partial product, lower = remaining multiplier bits / product low half
//   DIVU : upper = remainder,       lower = dividend bits shifting out / quotient shifting in
// The quotient bit is returned separately; bit 0 of acc_next is left 0 on a divide
// step and the caller merges q_bit into it.
module mdu_step
    import pipe_mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  acc,
    input  logic [WIDTH-1:0]  operand,
    input  mdu_op_e           op,
    output logic [2*WIDTH:0]  acc_next,
    output logic              q_bit
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;

    // Both datapaths are cheap; select on op at the end.
    always_comb begin
        mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        // One extra bit so the sign of the trial subtraction is always visible.
        div_diff  = {1'b0, div_shift} - {2'b00, operand};
        acc_next  = '0;
        q_bit     = 1'b0;
        if (op == MDU_MULTU) begin
            acc_next = {1'b0, mul_sum, acc[WIDTH-1:1]};
        end else begin
            q_bit = ~div_diff[WIDTH+1];
            if (q_bit) begin
                acc_next = {div_diff[WIDTH:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {div_shift, acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/pipe_mdu_ctrl.sv
// Iterative MULTU/DIVU sequencer with pipeline stall and architectural HI/LO.
//
// state    | meaning
// ---------+------------------------------------------------------------
// MDU_IDLE | waiting; MTHI/MTLO write here, MULTU/DIVU latch operands
// MDU_RUN  | one multiply/divide step per cycle, WIDTH steps in total
// MDU_DONE | results committed; instruction leaves EXE this cycle
module pipe_mdu_ctrl
    import pipe_mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32    // must match the interface instance
) (
    input  logic          clock,
    input  logic          reset,
    pipe_mdu_ctrl_if.slave mdu
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*WIDTH:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    mdu_op_e           op_q, op_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              mstall_c;

    mdu_op_e           op_in;
    logic [2*WIDTH:0]  step_acc;
    logic [2*WIDTH:0]  run_acc;
    logic              step_q_bit;

    assign op_in = mdu_op_e'(mdu.eop);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .operand  (opnd_q),
        .op       (op_q),
        .acc_next (step_acc),
        .q_bit    (step_q_bit)
    );

    assign run_acc = {step_acc[2*WIDTH:1], step_acc[0] | step_q_bit};

    // Next-state, datapath update and combinational stall.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mstall_c = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (mdu.estart && !mdu.ecancel) begin
                    if (is_long_op(op_in)) begin
                        mstall_c = 1'b1;
                        state_d  = MDU_RUN;
                        cnt_d    = '0;
                        op_d     = op_in;
                        // Multiplicand / divisor stays put; multiplier / dividend shifts.
                        if (op_in == MDU_MULTU) begin
                            opnd_d = mdu.ea;
                            acc_d  = {{(WIDTH+1){1'b0}}, mdu.eb};
                        end else begin
                            opnd_d = mdu.eb;
                            acc_d  = {{(WIDTH+1){1'b0}}, mdu.ea};
                        end
                    end else if (op_in == MDU_MTHI) begin
                        hi_d = mdu.ea;
                    end else begin
                        lo_d = mdu.ea;
                    end
                end
            end
            MDU_RUN: begin
                if (mdu.ecancel) begin
                    state_d = MDU_IDLE;
                end else begin
                    mstall_c = 1'b1;
                    acc_d    = run_acc;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        // Same slicing serves both: {hi,lo}=product, hi=rem, lo=quot.
                        hi_d    = run_acc[2*WIDTH-1:WIDTH];
                        lo_d    = run_acc[WIDTH-1:0];
                        state_d = MDU_DONE;
                    end
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
        busy_d = (state_d == MDU_RUN);
    end

    // State, datapath and HI/LO registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= MDU_MULTU;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign mdu.mstall = mstall_c;
    assign mdu.mbusy  = busy_q;
    assign mdu.hi     = hi_q;
    assign mdu.lo     = lo_q;

endmodule

// File: doc/pipe_mdu_ctrl.md
# pipe_mdu_ctrl

Iterative multiply/divide sequencer attached to the EXE stage of the five-stage pipeline. It accepts MULTU/DIVU/MTHI/MTLO from EXE, runs a 32-step shift-add or restoring-divide loop, and holds the pipeline with a stall until HI/LO are committed. It owns the architectural HI/LO registers, which the EXE result mux reads for MFHI/MFLO. ALU operations bypass this block entirely.

## Interface

Parameters:
- `WIDTH`, 32: operand width. Also the iteration count.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `estart`  in  1  a valid MDU instruction is in EXE.
- `eop`  in  2  operation: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
- `ea`  in  WIDTH  rs operand, already forwarded; multiplicand or dividend.
- `eb`  in  WIDTH  rt operand, already forwarded; multiplier or divisor.
- `ecancel`  in  1  the EXE instruction is squashed.
- `mstall`  out  1  hold PC, IF/ID and ID/EXE; insert a bubble into EXE/MEM.
- `mbusy`  out  1  state is RUN.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation

- FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - `estart` with MULTU or DIVU:
    - latch `ea`/`eb` into operand registers;
    - clear the step counter and the partial result;
    - go to RUN.
  - `estart` with MTHI writes `hi <= ea` at the clock edge. MTLO writes `lo <= ea` the same way. Stay in IDLE.
- **RUN**: one step per cycle; counter increments.
  - MULTU step (shift-add): if the multiplier LSB is 1, add the multiplicand into the upper half of the 64-bit accumulator; then shift right by one.
  - DIVU step (restoring): shift the remainder/quotient pair left; subtract the divisor; if the result is non-negative keep it and set the quotient bit, otherwise restore.
  - The step with counter = WIDTH-1 writes the results and moves to DONE:
    - MULTU: `{hi,lo}` = 64-bit product.
    - DIVU: `hi` = remainder, `lo` = quotient.
- **DONE**: lasts one cycle, then go to IDLE unconditionally. `estart` is ignored here because it is the same instruction leaving EXE.
- **Divide by zero** (`eb`=0 at start): still runs the full WIDTH steps. Result is `hi` = dividend, `lo` = all ones.
- **`mstall`**
  - = `estart` & (`eop` is MULTU/DIVU) & state==IDLE & ~`ecancel`; or
  - = state==RUN & ~`ecancel`.
  - It is low in DONE.
- **`ecancel`**
  - In RUN: abort to IDLE next cycle; `hi`/`lo` are not written.
  - In IDLE: suppresses the start or the MTHI/MTLO write.
- **Width rules**: accumulator and remainder are WIDTH+1 bits internally. Products are unsigned and never overflow 2·WIDTH.

## Timing

- **Reset**
  - State = IDLE; `hi` = `lo` = 0; counter = 0.
  - `mstall` = 0 and `mbusy` = 0.
  - Reset in any state, including mid-RUN, discards the operation.
- **Latency**, with start accepted in cycle 0:
  - RUN covers cycles 1..WIDTH.
  - DONE is cycle WIDTH+1, with `hi`/`lo` updated at the end of cycle WIDTH.
  - `mstall` is high in cycles 0..WIDTH, i.e. 33 cycles for WIDTH=32.
  - The instruction leaves EXE at the end of cycle WIDTH+1.
- **MTHI/MTLO**: zero stall; the new value is visible the next cycle.
- **Back-to-back MDU ops**: the second one sees IDLE the cycle after DONE and starts there.
- **MFHI directly after a MULTU** reads the committed `hi`, because the stall guarantees ordering.
- **`mbusy`** is registered. **`mstall`** is combinational from `estart`/`eop`/`ecancel` and state.

## Structure

- Shared package: `eop` encodings (`MDU_MULTU`, `MDU_DIVU`, `MDU_MTHI`, `MDU_MTLO`) and state encodings (`MDU_IDLE`, `MDU_RUN`, `MDU_DONE`).
- `pipe_mdu_ctrl` contains the FSM, counter, stall logic and HI/LO.
- One sub-module, `mdu_step`: combinational single-iteration datapath. Inputs: accumulator, operand, op. Output: next accumulator and quotient bit.
- Counter width is clog2(WIDTH).

## Test plan

- **MULTU**: `ea`=32'hFFFFFFFF, `eb`=32'hFFFFFFFF.
  - `mstall` high exactly 33 cycles; DONE in cycle 33.
  - `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
- **DIVU**: `ea`=100, `eb`=7 → `lo`=14, `hi`=2 after 32 RUN cycles.
- **DIVU by zero**: `ea`=32'h12345678, `eb`=0 → `hi`=32'h12345678, `lo`=32'hFFFFFFFF.
- **MTHI then immediate MULTU**:
  - MTHI `ea`=5 → `hi`=5 next cycle, no stall.
  - MULTU 3×4 starts the following cycle → `hi`=0, `lo`=12.
- **`ecancel` mid-op**: asserted in RUN cycle 10 → IDLE next cycle, `hi`/`lo` keep their prior values, `mstall` drops with `ecancel`.
- **Reset in RUN cycle 20**:
  - All outputs return to 0.
  - A new MULTU 2×3 then completes with `lo`=6.
